// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among ALU, LB and ACU result
// producers, with a single registered broadcast stage onto the CDB.

module cdb_arbiter_slot #(
    parameter int IDX = 0
) (
    input  logic [1:0] rr_ptr_i,
    output logic [1:0] rank_o
);
    // Rank is this source's cyclic distance from rr_ptr; rank 0 wins.
    // The 2-bit wrap keeps the result correct because the true distance is always below 3.
    assign rank_o = (2'(IDX) >= rr_ptr_i) ? 2'(IDX) - rr_ptr_i
                                          : 2'(IDX) + 2'd3 - rr_ptr_i;
endmodule

module cdb_arbiter #(
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              alu_wr_valid,
    input  logic [TAG_W-1:0]  alu_wr_tag,
    input  logic [DATA_W-1:0] alu_wr_value,
    output logic              alu_wr_written,
    input  logic              lb_wr_valid,
    input  logic [TAG_W-1:0]  lb_wr_tag,
    input  logic [DATA_W-1:0] lb_wr_value,
    output logic              lb_wr_written,
    input  logic              acu_wr_valid,
    input  logic [TAG_W-1:0]  acu_wr_tag,
    input  logic [DATA_W-1:0] acu_wr_value,
    output logic              acu_wr_written,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_value,
    output logic [1:0]        cdb_src
);
    localparam int NSRC = 3;

    logic [NSRC-1:0]             req;
    logic [NSRC-1:0][TAG_W-1:0]  tag_in;
    logic [NSRC-1:0][DATA_W-1:0] val_in;
    logic [NSRC-1:0][1:0]        rank;
    logic [NSRC-1:0]             grant;

    logic [1:0]        gsel;
    logic [TAG_W-1:0]  gtag;
    logic [DATA_W-1:0] gval;
    logic              any_grant;

    logic [1:0]        rr_ptr_q,    rr_ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q,   cdb_tag_d;
    logic [DATA_W-1:0] cdb_value_q, cdb_value_d;
    logic [1:0]        cdb_src_q,   cdb_src_d;

    assign req    = {acu_wr_valid, lb_wr_valid, alu_wr_valid};
    assign tag_in = {acu_wr_tag, lb_wr_tag, alu_wr_tag};
    assign val_in = {acu_wr_value, lb_wr_value, alu_wr_value};

    for (genvar i = 0; i < NSRC; i++) begin : g_slot
        cdb_arbiter_slot #(.IDX(i)) u_slot (
            .rr_ptr_i (rr_ptr_q),
            .rank_o   (rank[i])
        );
    end

    // A requester wins unless another requester sits closer to rr_ptr.
    always_comb begin
        grant = '0;
        for (int i = 0; i < NSRC; i++) begin
            grant[i] = req[i] & ~flush & ~reset;
            for (int j = 0; j < NSRC; j++) begin
                if (j != i && req[j] && rank[j] < rank[i]) grant[i] = 1'b0;
            end
        end
    end

    always_comb begin
        gsel = '0;
        gtag = '0;
        gval = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (grant[i]) begin
                gsel = 2'(i);
                gtag = tag_in[i];
                gval = val_in[i];
            end
        end
    end

    assign any_grant      = |grant;
    assign alu_wr_written = grant[0];
    assign lb_wr_written  = grant[1];
    assign acu_wr_written = grant[2];

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = any_grant;
        cdb_tag_d   = cdb_tag_q;
        cdb_value_d = cdb_value_q;
        cdb_src_d   = cdb_src_q;
        if (any_grant) begin
            rr_ptr_d    = (gsel == 2'd2) ? 2'd0 : gsel + 2'd1;
            cdb_tag_d   = gtag;
            cdb_value_d = gval;
            cdb_src_d   = gsel;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
            cdb_src_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_value_q <= cdb_value_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_value = cdb_value_q;
    assign cdb_src   = cdb_src_q;

    a_grant_onehot: assert property (@(posedge clock) $onehot0(grant));
    a_grant_valid:  assert property (@(posedge clock) (grant & ~req) == '0);
    a_ptr_range:    assert property (@(posedge clock) disable iff (reset) rr_ptr_q != 2'd3);
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed-vector bench for cdb_arbiter: grant order, broadcast latency,
// flush squash, idle hold and mid-stream reset.

module tb_cdb_arbiter;
    logic        clock = 1'b0;
    logic        reset, flush;
    logic        alu_wr_valid, lb_wr_valid, acu_wr_valid;
    logic [4:0]  alu_wr_tag, lb_wr_tag, acu_wr_tag;
    logic [31:0] alu_wr_value, lb_wr_value, acu_wr_value;
    logic        alu_wr_written, lb_wr_written, acu_wr_written;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic [1:0]  cdb_src;

    int n_vec = 0;
    int n_err = 0;

    wire [2:0]  wr  = {acu_wr_written, lb_wr_written, alu_wr_written};
    wire [39:0] bus = {cdb_valid, cdb_src, cdb_tag, cdb_value};

    cdb_arbiter #(.TAG_W(5), .DATA_W(32)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .alu_wr_valid(alu_wr_valid), .alu_wr_tag(alu_wr_tag), .alu_wr_value(alu_wr_value),
        .alu_wr_written(alu_wr_written),
        .lb_wr_valid(lb_wr_valid), .lb_wr_tag(lb_wr_tag), .lb_wr_value(lb_wr_value),
        .lb_wr_written(lb_wr_written),
        .acu_wr_valid(acu_wr_valid), .acu_wr_tag(acu_wr_tag), .acu_wr_value(acu_wr_value),
        .acu_wr_written(acu_wr_written),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_src(cdb_src)
    );

    always #5 clock = ~clock;

    function automatic logic [4:0] etag(int s);
        case (s)
            0:       return 5'd1;
            1:       return 5'd2;
            default: return 5'd3;
        endcase
    endfunction

    function automatic logic [31:0] eval(int s);
        case (s)
            0:       return 32'hAAAA_0001;
            1:       return 32'hBBBB_0002;
            default: return 32'hCCCC_0003;
        endcase
    endfunction

    function automatic logic [39:0] ebus(int s);
        return {1'b1, 2'(s), etag(s), eval(s)};
    endfunction

    // Drive valids {acu,lb,alu} with the fixed per-source tag/value; settle 1 time unit.
    task automatic drive(input logic [2:0] v);
        {acu_wr_valid, lb_wr_valid, alu_wr_valid} = v;
        alu_wr_tag = etag(0); alu_wr_value = eval(0);
        lb_wr_tag  = etag(1); lb_wr_value  = eval(1);
        acu_wr_tag = etag(2); acu_wr_value = eval(2);
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0;
        drive(3'b000);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b1;
        drive(3'b111);
        n_vec++;
        if (wr !== 3'b000) begin
            n_err++; $display("FAIL reset_written: got %b want 000", wr);
        end
        tick();
        n_vec++;
        if (bus !== 40'd0) begin
            n_err++; $display("FAIL reset_bus: got %h want 0", bus);
        end
        n_vec++;
        if (dut.rr_ptr_q !== 2'd0) begin
            n_err++; $display("FAIL reset_ptr: got %0d want 0", dut.rr_ptr_q);
        end
        reset = 1'b0; flush = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        drive(3'b010);
        lb_wr_tag = 5'd7; lb_wr_value = 32'hDEAD_BEEF;
        #1;
        n_vec++;
        if (wr !== 3'b010) begin
            n_err++; $display("FAIL single_written: got %b want 010", wr);
        end
        tick();
        n_vec++;
        if (bus !== {1'b1, 2'd1, 5'd7, 32'hDEAD_BEEF}) begin
            n_err++; $display("FAIL single_bus: got %h want %h", bus, {1'b1, 2'd1, 5'd7, 32'hDEAD_BEEF});
        end
        n_vec++;
        if (dut.rr_ptr_q !== 2'd2) begin
            n_err++; $display("FAIL single_ptr: got %0d want 2", dut.rr_ptr_q);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(3'b111);
            n_vec++;
            if (wr !== 3'(1 << (k % 3))) begin
                n_err++; $display("FAIL rr_written[%0d]: got %b want %b", k, wr, 3'(1 << (k % 3)));
            end
            tick();
            n_vec++;
            if (bus !== ebus(k % 3)) begin
                n_err++; $display("FAIL rr_bus[%0d]: got %h want %h", k, bus, ebus(k % 3));
            end
        end
        // Idle: valid drops, fields keep the last (ACU) broadcast.
        drive(3'b000);
        n_vec++;
        if (wr !== 3'b000) begin
            n_err++; $display("FAIL rr_idle_written: got %b want 000", wr);
        end
        tick();
        n_vec++;
        if (bus !== {1'b0, ebus(2)[38:0]}) begin
            n_err++; $display("FAIL rr_idle_bus: got %h want %h", bus, {1'b0, ebus(2)[38:0]});
        end
    endtask

    task automatic test_skip();
        do_reset();
        drive(3'b001);
        tick();
        n_vec++;
        if (dut.rr_ptr_q !== 2'd1) begin
            n_err++; $display("FAIL skip_ptr_setup: got %0d want 1", dut.rr_ptr_q);
        end
        drive(3'b101);
        n_vec++;
        if (wr !== 3'b100) begin
            n_err++; $display("FAIL skip_first: got %b want 100", wr);
        end
        tick();
        n_vec++;
        if (dut.rr_ptr_q !== 2'd0 || bus !== ebus(2)) begin
            n_err++; $display("FAIL skip_after_acu: got ptr %0d bus %h want ptr 0 bus %h", dut.rr_ptr_q, bus, ebus(2));
        end
        drive(3'b101);
        n_vec++;
        if (wr !== 3'b001) begin
            n_err++; $display("FAIL skip_second: got %b want 001", wr);
        end
        tick();
        n_vec++;
        if (dut.rr_ptr_q !== 2'd1 || bus !== ebus(0)) begin
            n_err++; $display("FAIL skip_after_alu: got ptr %0d bus %h want ptr 1 bus %h", dut.rr_ptr_q, bus, ebus(0));
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(3'b111);
        tick();
        flush = 1'b1;
        drive(3'b111);
        n_vec++;
        if (wr !== 3'b000) begin
            n_err++; $display("FAIL flush_written: got %b want 000", wr);
        end
        n_vec++;
        if (bus !== ebus(0)) begin
            n_err++; $display("FAIL flush_bus_visible: got %h want %h", bus, ebus(0));
        end
        tick();
        flush = 1'b0;
        n_vec++;
        if (bus !== {1'b0, ebus(0)[38:0]} || dut.rr_ptr_q !== 2'd1) begin
            n_err++; $display("FAIL flush_after: got bus %h ptr %0d want bus %h ptr 1", bus, dut.rr_ptr_q, {1'b0, ebus(0)[38:0]});
        end
        drive(3'b111);
        n_vec++;
        if (wr !== 3'b010) begin
            n_err++; $display("FAIL flush_resume: got %b want 010", wr);
        end
        tick();
        n_vec++;
        if (bus !== ebus(1)) begin
            n_err++; $display("FAIL flush_resume_bus: got %h want %h", bus, ebus(1));
        end
    endtask

    task automatic test_idle_midreset();
        // Continues from LB broadcast left by test_flush (rr_ptr = 2).
        for (int k = 0; k < 3; k++) begin
            drive(3'b000);
            tick();
            n_vec++;
            if (bus !== {1'b0, ebus(1)[38:0]}) begin
                n_err++; $display("FAIL idle_hold[%0d]: got %h want %h", k, bus, {1'b0, ebus(1)[38:0]});
            end
        end
        drive(3'b111);
        tick();
        drive(3'b111);
        tick();
        reset = 1'b1;
        drive(3'b111);
        n_vec++;
        if (wr !== 3'b000) begin
            n_err++; $display("FAIL midreset_written: got %b want 000", wr);
        end
        tick();
        reset = 1'b0;
        n_vec++;
        if (bus !== 40'd0 || dut.rr_ptr_q !== 2'd0) begin
            n_err++; $display("FAIL midreset_bus: got bus %h ptr %0d want 0 0", bus, dut.rr_ptr_q);
        end
        drive(3'b111);
        n_vec++;
        if (wr !== 3'b001) begin
            n_err++; $display("FAIL midreset_first_grant: got %b want 001", wr);
        end
        tick();
        n_vec++;
        if (bus !== ebus(0)) begin
            n_err++; $display("FAIL midreset_first_bus: got %h want %h", bus, ebus(0));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_skip();
        test_flush();
        test_idle_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
